wb_initiator: RTL and testbench

Single-transaction Wishbone classic initiator: accepts read/write commands on a valid/ready command port, runs one Wishbone bus cycle per command, and returns read data and status on a valid/ready response port. It lets user-area logic (LA-probe sequencers, self-test engines) drive the user-area Wishbone targets, such as the counter slave, from the initiator side, without the management SoC.

---
 rtl/wb_initiator_pkg.sv | 13 +
 rtl/wb_initiator_timer.sv | 30 +++
 rtl/wb_initiator.sv | 129 ++++++++++++
 tb/tb_wb_initiator.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the wb_initiator Wishbone classic initiator.
package wb_initiator_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int          TMR_W            = 16;
   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_initiator_timer.sv
// Bus-cycle timeout counter for wb_initiator; only instantiated when the
// WB_INITIATOR_TIMEOUT_EN build option is defined.
module wb_initiator_timer
   import wb_initiator_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TMR_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + TMR_W'(1);
      end
   end

   // High during the wait cycle whose closing edge completes the TIMEOUT-th wait.
   assign expired = en && (cnt == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_initiator.sv
// Single-transaction Wishbone classic initiator with a valid/ready command and
// response port. Define WB_INITIATOR_TIMEOUT_EN to enable the ack timeout.
module wb_initiator
   import wb_initiator_pkg::*;
#(
   parameter int          TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   input  logic [3:0]  cmd_sel,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic        wbm_ack_i,
   input  logic [31:0] wbm_dat_i
);

   state_t      state, state_nxt;
   logic        bus_end;
   logic        we_q;
   logic [3:0]  sel_q;
   logic [31:0] adr_q, dat_q;
   logic [31:0] rsp_dat_q, rsp_dat_nxt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: default assignment first keeps this combinational block latch-free.
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid) state_nxt = BUS;
         BUS:     if (bus_end)   state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Decoded from state alone, so reset drops cyc/stb without waiting for a clock.
   always_comb begin
      cmd_ready = (state == IDLE);
      rsp_valid = (state == RESP);
      wbm_cyc_o = (state == BUS);
      wbm_stb_o = (state == BUS);
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         we_q  <= 1'b0;
         adr_q <= '0;
         dat_q <= '0;
         sel_q <= '0;
      end else if ((state == IDLE) && cmd_valid) begin
         we_q  <= cmd_we;
         adr_q <= cmd_adr;
         dat_q <= cmd_dat;
         sel_q <= cmd_sel;
      end
   end

   assign wbm_we_o  = we_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;
   assign wbm_sel_o = sel_q;

`ifdef WB_INITIATOR_TIMEOUT_EN
   logic tmo;
   logic rsp_err_q;

   wb_initiator_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_ni),
      .clr     (state != BUS),
      .en      ((state == BUS) && !wbm_ack_i),
      .expired (tmo)
   );

   // An ack on the expiry edge wins: expired is already gated off by ack.
   assign bus_end     = wbm_ack_i || tmo;
   assign rsp_dat_nxt = we_q      ? '0        :
                        wbm_ack_i ? wbm_dat_i : ERR_DATA;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         rsp_err_q <= 1'b0;
      end else if ((state == BUS) && bus_end) begin
         rsp_err_q <= !wbm_ack_i;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   assign bus_end     = wbm_ack_i;
   assign rsp_dat_nxt = we_q ? '0 : wbm_dat_i;
   assign rsp_err     = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         rsp_dat_q <= '0;
      end else if ((state == BUS) && bus_end) begin
         rsp_dat_q <= rsp_dat_nxt;
      end
   end

   assign rsp_dat = rsp_dat_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed testbench for wb_initiator: transaction-level model plus per-cycle
// compare, and literal latency/data expectations for each scenario.
module tb_wb_initiator;

   localparam int          TIMEOUT  = 8;
   localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
`ifdef WB_INITIATOR_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam int PH_IDLE = 0, PH_BUS = 1, PH_RESP = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
   logic [31:0] cmd_adr = '0, cmd_dat = '0;
   logic [3:0]  cmd_sel = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [31:0] rsp_dat;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic        wbm_ack_i = 1'b0;
   logic [31:0] wbm_dat_i = '0;

   int checks = 0;
   int failures = 0;

   wb_initiator #(
      .TIMEOUT  (TIMEOUT),
      .ERR_DATA (ERR_DATA)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_adr   (cmd_adr),
      .cmd_dat   (cmd_dat),
      .cmd_sel   (cmd_sel),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_dat   (rsp_dat),
      .rsp_err   (rsp_err),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_ack_i (wbm_ack_i),
      .wbm_dat_i (wbm_dat_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Target: acks after tgt_wait stalled strobe cycles, junk data otherwise;
   // tgt_force raises a spurious ack, tgt_never suppresses the normal ack.
   int          tgt_wait = 0;
   int          tgt_cnt = 0;
   bit          tgt_never = 1'b0;
   bit          tgt_force = 1'b0;
   logic [31:0] tgt_rdata = '0;

   always @(posedge clk) begin
      #1;
      if (wbm_cyc_o && wbm_stb_o && !tgt_never && tgt_cnt == tgt_wait) begin
         wbm_ack_i = 1'b1;
         wbm_dat_i = tgt_rdata;
      end else begin
         wbm_ack_i = tgt_force;
         wbm_dat_i = $urandom;
      end
      tgt_cnt = (wbm_cyc_o && wbm_stb_o) ? tgt_cnt + 1 : 0;
   end

   // Transaction model: which phase the one outstanding command is in, what it
   // asked for, and the response it must produce.
   int          m_phase;
   int          m_waited;
   logic        m_we, m_rsp_err;
   logic [3:0]  m_sel;
   logic [31:0] m_adr, m_dat, m_rsp_dat;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase   <= PH_IDLE;
         m_waited  <= 0;
         m_rsp_dat <= '0;
         m_rsp_err <= 1'b0;
      end else begin
         case (m_phase)
            PH_IDLE: if (cmd_valid) begin
               m_phase  <= PH_BUS;
               m_waited <= 0;
               m_we     <= cmd_we;
               m_adr    <= cmd_adr;
               m_dat    <= cmd_dat;
               m_sel    <= cmd_sel;
            end
            PH_BUS: if (wbm_ack_i) begin
               m_phase   <= PH_RESP;
               m_rsp_dat <= m_we ? 32'h0 : wbm_dat_i;
               m_rsp_err <= 1'b0;
            end else if (TMO_EN && (m_waited + 1 == TIMEOUT)) begin
               m_phase   <= PH_RESP;
               m_rsp_dat <= m_we ? 32'h0 : ERR_DATA;
               m_rsp_err <= 1'b1;
            end else begin
               m_waited <= m_waited + 1;
            end
            default: if (rsp_ready) m_phase <= PH_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_cmd_ready", cmd_ready, 1);
         check("rst_rsp_valid", rsp_valid, 0);
         check("rst_rsp_dat", rsp_dat, 0);
         check("rst_rsp_err", rsp_err, 0);
         check("rst_cyc_stb", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
         check("rst_adr", wbm_adr_o, 0);
         check("rst_dat", wbm_dat_o, 0);
         check("rst_sel", wbm_sel_o, 0);
      end else begin
         check("cmd_ready", cmd_ready, m_phase == PH_IDLE);
         check("rsp_valid", rsp_valid, m_phase == PH_RESP);
         check("cyc", wbm_cyc_o, m_phase == PH_BUS);
         check("stb", wbm_stb_o, m_phase == PH_BUS);
         check("rsp_dat", rsp_dat, m_rsp_dat);
         check("rsp_err", rsp_err, m_rsp_err);
         if (m_phase == PH_BUS) begin
            check("bus_we", wbm_we_o, m_we);
            check("bus_adr", wbm_adr_o, m_adr);
            check("bus_dat", wbm_dat_o, m_dat);
            check("bus_sel", wbm_sel_o, m_sel);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send_cmd(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
      int n = 0;
      cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("cmd_accept", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
   endtask

   // lat counts falling edges from the first after acceptance up to the one
   // showing rsp_valid; cyc_n counts falling edges with cyc high.
   task automatic xact(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int wait_n, input logic [31:0] rdata,
                       input int hold, input bit prearm, input bit spur,
                       output int lat, output logic [31:0] got_dat, output logic got_err,
                       output int cyc_n);
      int ready_hi = 0;
      tgt_wait = wait_n; tgt_rdata = rdata; rsp_ready = prearm;
      send_cmd(we, adr, dat, sel);
      @(negedge clk);
      lat = 1;
      cyc_n = 0;
      check("first_bus_cyc", wbm_cyc_o, 1);
      check("first_bus_fields", {wbm_we_o, wbm_sel_o, wbm_adr_o ^ wbm_dat_o}, {we, sel, adr ^ dat});
      check("first_bus_adr", wbm_adr_o, adr);
      while (!rsp_valid && lat < 200) begin
         if (wbm_cyc_o) cyc_n++;
         if (cmd_ready) ready_hi++;
         @(negedge clk);
         lat++;
      end
      check("rsp_valid_seen", rsp_valid, 1);
      got_dat = rsp_dat;
      got_err = rsp_err;
      for (int i = 0; i < hold; i++) begin
         tgt_force = spur;
         @(negedge clk);
         if (wbm_cyc_o) cyc_n++;
         if (cmd_ready) ready_hi++;
         check("hold_rsp_valid", rsp_valid, 1);
         check("hold_rsp_dat", rsp_dat, got_dat);
      end
      tgt_force = 1'b0;
      check("cmd_ready_low_busy", ready_hi, 0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("idle_after_consume", {cmd_ready, rsp_valid}, 2'b10);
   endtask

   int          lat, cyc_n;
   logic [31:0] d;
   logic        e;

   initial begin
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // Write, target acks one cycle after strobe.
      xact(1'b1, 32'h3000_0000, 32'h1234_5678, 4'hF, 1, 32'h0, 0, 1'b0, 1'b0, lat, d, e, cyc_n);
      check("wr_latency", lat, 3);
      check("wr_rsp_dat", d, 32'h0);
      check("wr_rsp_err", e, 0);
      check("wr_cyc_cycles", cyc_n, 2);

      // Read with four wait cycles.
      xact(1'b0, 32'h3000_0008, 32'h0, 4'hF, 4, 32'hCAFE_F00D, 0, 1'b0, 1'b0, lat, d, e, cyc_n);
      check("rd4_rsp_dat", d, 32'hCAFE_F00D);
      check("rd4_cyc_cycles", cyc_n, 5);
      check("rd4_latency", lat, 6);

      // First-cycle ack with rsp_ready held high in advance.
      xact(1'b0, 32'h3000_000C, 32'h0, 4'h3, 0, 32'h0BAD_F00D, 0, 1'b1, 1'b0, lat, d, e, cyc_n);
      check("rd0_latency", lat, 2);
      check("rd0_rsp_dat", d, 32'h0BAD_F00D);

      // Backpressure for 10 cycles with spurious acks during RESP.
      xact(1'b0, 32'h3000_0010, 32'h0, 4'hC, 2, 32'hA5A5_5A5A, 10, 1'b0, 1'b1, lat, d, e, cyc_n);
      check("bp_rsp_dat", d, 32'hA5A5_5A5A);
      check("bp_cyc_cycles", cyc_n, 3);
      check("bp_rsp_dat_after", rsp_dat, 32'hA5A5_5A5A);

      // Zero byte enables still run a bus cycle.
      xact(1'b1, 32'h3000_0004, 32'hFFFF_0000, 4'h0, 0, 32'h0, 0, 1'b0, 1'b0, lat, d, e, cyc_n);
      check("sel0_cyc_cycles", cyc_n, 1);
      check("sel0_rsp_dat", d, 32'h0);

      // Spurious acks while idle.
      tgt_force = 1'b1;
      repeat (3) @(posedge clk);
      #1 tgt_force = 1'b0;
      @(posedge clk); #1;
      check("idle_spur_state", {cmd_ready, rsp_valid, wbm_cyc_o}, 3'b100);
      check("idle_spur_rsp_dat", rsp_dat, 32'h0);

      // Reset in the middle of a bus cycle.
      tgt_never = 1'b1;
      send_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF);
      repeat (2) @(negedge clk);
      check("pre_rst_cyc", wbm_cyc_o, 1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("rst_drops_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 2'b00);
      check("rst_no_rsp", {rsp_valid, cmd_ready}, 2'b01);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      tgt_never = 1'b0;
      @(posedge clk); #1;
      xact(1'b0, 32'h3000_0024, 32'h0, 4'hF, 1, 32'h1357_9BDF, 0, 1'b0, 1'b0, lat, d, e, cyc_n);
      check("post_rst_rsp_dat", d, 32'h1357_9BDF);
      check("post_rst_latency", lat, 3);

`ifdef WB_INITIATOR_TIMEOUT_EN
      tgt_never = 1'b1;
      xact(1'b0, 32'h3000_0030, 32'h0, 4'hF, 0, 32'h0, 0, 1'b0, 1'b0, lat, d, e, cyc_n);
      check("tmo_rd_cyc_cycles", cyc_n, 8);
      check("tmo_rd_rsp_err", e, 1);
      check("tmo_rd_rsp_dat", d, 32'hDEAD_BEEF);
      xact(1'b1, 32'h3000_0034, 32'h5555_AAAA, 4'hF, 0, 32'h0, 0, 1'b0, 1'b0, lat, d, e, cyc_n);
      check("tmo_wr_rsp", {e, d}, {1'b1, 32'h0});
      tgt_never = 1'b0;
      xact(1'b0, 32'h3000_0038, 32'h0, 4'hF, 7, 32'h2468_ACE0, 0, 1'b0, 1'b0, lat, d, e, cyc_n);
      check("ack_at_expiry_err", e, 0);
      check("ack_at_expiry_dat", d, 32'h2468_ACE0);
      check("ack_at_expiry_cyc", cyc_n, 8);
`else
      // Without the timeout the bus waits well past TIMEOUT for an ack.
      tgt_never = 1'b1;
      send_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hF);
      cyc_n = 0;
      repeat (20) begin
         @(negedge clk);
         if (wbm_cyc_o) cyc_n++;
      end
      check("no_tmo_cyc_cycles", cyc_n, 20);
      check("no_tmo_rsp_valid", rsp_valid, 0);
      tgt_force = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 5);
      tgt_force = 1'b0;
      tgt_never = 1'b0;
      check("late_ack_rsp", {rsp_valid, rsp_err}, 2'b10);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
`endif

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
